// File: rtl/neopixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_pkg
// Description : Shared NeoPixel timing constants and receiver state encoding
//               (used by both the receiver and the transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package neopixel_pkg;

    // Line timing in 50 MHz system clocks.
    localparam int C_T_THRESH       = 30;    // high >= this decodes as '1'
    localparam int C_T_MIN          = 5;     // shorter high pulses are glitches
    localparam int C_T_MAX          = 60;    // high pulse reaching this is an error
    localparam int C_T_LATCH        = 2500;  // 50 us low ends a frame
    localparam int C_BITS_PER_PIXEL = 24;    // GRB, MSB first

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/neo_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : neo_sync_edge
// Description : Two-flop synchronizer for the asynchronous NeoPixel line with
//               single-cycle rise/fall detection on the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module neo_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_data,
    output logic d_s,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the line and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign d_s  = r_sync;
    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/neopixel_rx.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_rx
// Description : WS2812-style serial decoder. Measures each high pulse on the
//               synchronized line, assembles 24-bit GRB words MSB first, and
//               flags end of frame on the long-low latch interval.
// Revision    : 1.0 - initial release
// ============================================================================
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int T_THRESH = C_T_THRESH,
    parameter int T_MIN    = C_T_MIN,
    parameter int T_MAX    = C_T_MAX,
    parameter int T_LATCH  = C_T_LATCH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        neo_data,
    output logic [23:0] pixel,
    output logic        pixel_valid,
    output logic [5:0]  pixel_index,
    output logic        frame_done,
    output logic [6:0]  frame_pixels,
    output logic        error
);

    localparam int C_BITS   = C_BITS_PER_PIXEL;
    localparam int C_HCNT_W = $clog2(T_MAX + 1);
    localparam int C_LCNT_W = $clog2(T_LATCH + 1);
    localparam int C_BCNT_W = $clog2(C_BITS);

    // Thresholds are compared one below the limit so counters stop before
    // they could ever exceed their sized width.
    localparam logic [C_HCNT_W-1:0] C_HTHRESH  = C_HCNT_W'(T_THRESH);
    localparam logic [C_HCNT_W-1:0] C_HMIN     = C_HCNT_W'(T_MIN);
    localparam logic [C_HCNT_W-1:0] C_HMAX_M1  = C_HCNT_W'(T_MAX - 1);
    localparam logic [C_LCNT_W-1:0] C_LATCH_M1 = C_LCNT_W'(T_LATCH - 1);
    localparam logic [C_BCNT_W-1:0] C_BIT_LAST = C_BCNT_W'(C_BITS - 1);

    logic w_d_s;
    logic w_rise;
    logic w_fall;

    rx_state_t r_state, w_state_nxt;

    logic [C_HCNT_W-1:0] r_high_cnt, w_high_cnt_nxt;
    logic [C_LCNT_W-1:0] r_low_cnt,  w_low_cnt_nxt;
    logic [C_BCNT_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic [C_BITS-1:0]   r_shift,    w_shift_nxt;
    logic [6:0]          r_pix_cnt,  w_pix_cnt_nxt;
    logic [5:0]          r_idx,      w_idx_nxt;

    logic [23:0] r_pixel,        w_pixel_nxt;
    logic        r_pixel_valid,  w_pixel_valid_nxt;
    logic [5:0]  r_pixel_index,  w_pixel_index_nxt;
    logic        r_frame_done,   w_frame_done_nxt;
    logic [6:0]  r_frame_pixels, w_frame_pixels_nxt;
    logic        r_error,        w_error_nxt;

    logic              w_bit;
    logic [C_BITS-1:0] w_shift_in;

    neo_sync_edge u_sync (
        .clk    (clock),
        .rst    (reset),
        .i_data (neo_data),
        .d_s    (w_d_s),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_bit      = (r_high_cnt >= C_HTHRESH);
    assign w_shift_in = {r_shift[C_BITS-2:0], w_bit};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, shift register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_high_cnt     <= '0;
            r_low_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_pix_cnt      <= '0;
            r_idx          <= '0;
            r_pixel        <= '0;
            r_pixel_valid  <= 1'b0;
            r_pixel_index  <= '0;
            r_frame_done   <= 1'b0;
            r_frame_pixels <= '0;
            r_error        <= 1'b0;
        end else begin
            r_high_cnt     <= w_high_cnt_nxt;
            r_low_cnt      <= w_low_cnt_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_shift        <= w_shift_nxt;
            r_pix_cnt      <= w_pix_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_pixel        <= w_pixel_nxt;
            r_pixel_valid  <= w_pixel_valid_nxt;
            r_pixel_index  <= w_pixel_index_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_frame_pixels <= w_frame_pixels_nxt;
            r_error        <= w_error_nxt;
        end
    end

    // Next-state and datapath decode: pulse measurement, bit assembly, latch.
    always_comb begin
        w_state_nxt        = r_state;
        w_high_cnt_nxt     = r_high_cnt;
        w_low_cnt_nxt      = r_low_cnt;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_shift_nxt        = r_shift;
        w_pix_cnt_nxt      = r_pix_cnt;
        w_idx_nxt          = r_idx;
        w_pixel_nxt        = r_pixel;
        w_pixel_valid_nxt  = 1'b0;
        w_pixel_index_nxt  = r_pixel_index;
        w_frame_done_nxt   = 1'b0;
        w_frame_pixels_nxt = r_frame_pixels;
        w_error_nxt        = r_error;

        case (r_state)
            SYNC: begin
                // Wait for a full latch interval of quiet line before decoding.
                if (w_d_s) begin
                    w_low_cnt_nxt = '0;
                end else if (r_low_cnt == C_LATCH_M1) begin
                    w_low_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_low_cnt_nxt = r_low_cnt + C_LCNT_W'(1);
                end
            end

            IDLE: begin
                if (w_rise) begin
                    w_high_cnt_nxt = C_HCNT_W'(1);
                    w_state_nxt    = HIGH;
                end
            end

            HIGH: begin
                if (w_fall) begin
                    if (r_high_cnt < C_HMIN) begin
                        // Glitch: abandon the frame and resynchronize.
                        w_error_nxt   = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_low_cnt_nxt = '0;
                        w_pix_cnt_nxt = '0;
                        w_idx_nxt     = '0;
                        w_state_nxt   = SYNC;
                    end else begin
                        w_shift_nxt = w_shift_in;
                        if (r_bit_cnt == C_BIT_LAST) begin
                            w_pixel_nxt       = w_shift_in;
                            w_pixel_valid_nxt = 1'b1;
                            w_pixel_index_nxt = r_idx;
                            w_idx_nxt         = r_idx + 6'd1;
                            if (r_pix_cnt != 7'd127) begin
                                w_pix_cnt_nxt = r_pix_cnt + 7'd1;
                            end
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + C_BCNT_W'(1);
                        end
                        w_low_cnt_nxt = C_LCNT_W'(1);
                        w_state_nxt   = LOW;
                    end
                end else if (r_high_cnt == C_HMAX_M1) begin
                    // Stuck-high line: drop the partial pixel and resynchronize.
                    w_error_nxt   = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_low_cnt_nxt = '0;
                    w_pix_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                    w_state_nxt   = SYNC;
                end else begin
                    w_high_cnt_nxt = r_high_cnt + C_HCNT_W'(1);
                end
            end

            LOW: begin
                if (w_rise) begin
                    w_high_cnt_nxt = C_HCNT_W'(1);
                    w_state_nxt    = HIGH;
                end else if (r_low_cnt == C_LATCH_M1) begin
                    if (r_bit_cnt == '0) begin
                        w_frame_done_nxt   = 1'b1;
                        w_frame_pixels_nxt = r_pix_cnt;
                        w_pixel_index_nxt  = '0;
                    end else begin
                        // Latch arrived mid-pixel: the frame is malformed.
                        w_error_nxt = 1'b1;
                    end
                    w_bit_cnt_nxt = '0;
                    w_pix_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                    w_low_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_low_cnt_nxt = r_low_cnt + C_LCNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    assign pixel        = r_pixel;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_index  = r_pixel_index;
    assign frame_done   = r_frame_done;
    assign frame_pixels = r_frame_pixels;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_neopixel_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_neopixel_rx
// Description : Directed self-checking bench for neopixel_rx with a pixel and
//               frame scoreboard fed by the stimulus and drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neopixel_rx;

    logic        clock;
    logic        reset;
    logic        neo_data;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [5:0]  pixel_index;
    logic        frame_done;
    logic [6:0]  frame_pixels;
    logic        error;

    typedef struct {
        logic [23:0] word;
        logic [5:0]  index;
    } pix_exp_t;

    pix_exp_t   pix_q[$];
    logic [6:0] frm_q[$];
    pix_exp_t   e_pix;
    logic [6:0] e_frm;

    int checks = 0;
    int errors = 0;

    neopixel_rx dut (
        .clock        (clock),
        .reset        (reset),
        .neo_data     (neo_data),
        .pixel        (pixel),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .error        (error)
    );

    // 50 MHz system clock.
    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_high(input int n);
        neo_data = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_low(input int n);
        neo_data = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Send the top n bits of w, MSB first, with the given high times (62-cycle period).
    task automatic send_bits(input logic [23:0] w, input int n, input int h1, input int h0);
        for (int i = 23; i > 23 - n; i--) begin
            if (w[i]) begin
                send_high(h1);
                send_low(62 - h1);
            end else begin
                send_high(h0);
                send_low(62 - h0);
            end
        end
    endtask

    task automatic exp_pixel(input logic [23:0] w, input logic [5:0] idx);
        pix_exp_t p;
        p.word  = w;
        p.index = idx;
        pix_q.push_back(p);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        neo_data = 1'b0;

        // Monitor: every strobe must match the head of its scoreboard queue.
        fork
            forever begin
                @(negedge clock);
                if (pixel_valid === 1'b1) begin
                    chk("pixel_valid_expected", 32'(pix_q.size() != 0), 32'd1);
                    chk("no_frame_done_with_pixel", 32'(frame_done), 32'd0);
                    if (pix_q.size() != 0) begin
                        e_pix = pix_q.pop_front();
                        chk("pixel", 32'(pixel), 32'(e_pix.word));
                        chk("pixel_index", 32'(pixel_index), 32'(e_pix.index));
                    end
                end
                if (frame_done === 1'b1) begin
                    chk("frame_done_expected", 32'(frm_q.size() != 0), 32'd1);
                    if (frm_q.size() != 0) begin
                        e_frm = frm_q.pop_front();
                        chk("frame_pixels", 32'(frame_pixels), 32'(e_frm));
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clock);
        chk("reset_pixel", 32'(pixel), 32'd0);
        chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("reset_pixel_index", 32'(pixel_index), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_frame_pixels", 32'(frame_pixels), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        reset = 1'b0;

        // Single red pixel framed by latch intervals.
        send_low(2600);
        exp_pixel(24'hFF0000, 6'd0);
        send_bits(24'hFF0000, 24, 40, 20);
        frm_q.push_back(7'd1);
        send_low(2600);
        chk("single_error", 32'(error), 32'd0);
        chk("single_pixel_held", 32'(pixel), 32'hFF0000);
        chk("single_frame_pixels_held", 32'(frame_pixels), 32'd1);

        // Four-pixel frame.
        exp_pixel(24'h010203, 6'd0);
        exp_pixel(24'h00FF00, 6'd1);
        exp_pixel(24'h0000FF, 6'd2);
        exp_pixel(24'hAAAAAA, 6'd3);
        send_bits(24'h010203, 24, 40, 20);
        send_bits(24'h00FF00, 24, 40, 20);
        send_bits(24'h0000FF, 24, 40, 20);
        send_bits(24'hAAAAAA, 24, 40, 20);
        frm_q.push_back(7'd4);
        send_low(2600);
        chk("frame4_frame_pixels", 32'(frame_pixels), 32'd4);
        chk("frame4_error", 32'(error), 32'd0);

        // Threshold boundary: 30-cycle high is a 1, 29-cycle high is a 0.
        exp_pixel(24'h5A5A5A, 6'd0);
        send_bits(24'h5A5A5A, 24, 30, 29);
        frm_q.push_back(7'd1);
        send_low(2600);
        chk("boundary_error", 32'(error), 32'd0);

        // Glitch mid-pixel: error, no strobe, rest of the pixel ignored.
        send_bits(24'hF0F0F0, 5, 40, 20);
        send_high(3);
        send_low(22);
        send_bits(24'hF0F0F0, 18, 40, 20);
        send_low(2600);
        chk("glitch_error", 32'(error), 32'd1);
        exp_pixel(24'h123456, 6'd0);
        send_bits(24'h123456, 24, 40, 20);
        frm_q.push_back(7'd1);
        send_low(2600);
        chk("glitch_recover_error_sticky", 32'(error), 32'd1);

        // Partial pixel at latch: error, no frame_done.
        pulse_reset();
        send_low(2600);
        chk("partial_pre_error", 32'(error), 32'd0);
        send_bits(24'hABCDEF, 12, 40, 20);
        send_low(2600);
        chk("partial_error", 32'(error), 32'd1);

        // Over-long high pulse.
        pulse_reset();
        send_low(2600);
        chk("long_pre_error", 32'(error), 32'd0);
        send_high(70);
        send_low(2600);
        chk("long_high_error", 32'(error), 32'd1);

        // Reset after bit 10 while the stream continues.
        pulse_reset();
        send_low(2600);
        send_bits(24'h777777, 10, 40, 20);
        pulse_reset();
        send_bits(24'h777777 << 10, 14, 40, 20);
        send_bits(24'h333333, 24, 40, 20);
        send_low(2600);
        chk("midreset_no_strobe_pixel", 32'(pixel), 32'd0);
        exp_pixel(24'hC0FFEE, 6'd0);
        exp_pixel(24'h0F0F0F, 6'd1);
        send_bits(24'hC0FFEE, 24, 40, 20);
        send_bits(24'h0F0F0F, 24, 40, 20);
        frm_q.push_back(7'd2);
        send_low(2600);
        chk("midreset_error", 32'(error), 32'd0);

        // Every expected strobe must have appeared.
        chk("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
        chk("frame_queue_drained", 32'(frm_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
